// File: rtl/shared_memory_pkg.sv
// Shared constants and types for the shared-memory block master and its read FIFO.
package shared_memory_pkg;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int BEW = DW / 8;

  localparam logic [BEW-1:0] BE_ALL = '1;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    FINISH
  } state_e;

endpackage

// File: rtl/shared_memory_block_master_if.sv
// Command, stream and Avalon-MM signals of the shared-memory block master.
interface shared_memory_block_master_if;
  import shared_memory_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          done;

  logic [DW-1:0] snk_data;
  logic          snk_valid;
  logic          snk_ready;

  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;

  logic [AW-1:0]  avm_address;
  logic           avm_chipselect;
  logic           avm_write;
  logic [BEW-1:0] avm_byteenable;
  logic [DW-1:0]  avm_writedata;
  logic           avm_clken;
  logic [DW-1:0]  avm_readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready, done,
    input  snk_data, snk_valid,
    output snk_ready,
    output src_data, src_valid,
    input  src_ready,
    output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata, avm_clken,
    input  avm_readdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready, done,
    output snk_data, snk_valid,
    input  snk_ready,
    input  src_data, src_valid,
    output src_ready,
    input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata, avm_clken,
    output avm_readdata
  );

endinterface

// File: rtl/shared_memory_rd_fifo.sv
// Synchronous read-return FIFO; FIFO_DEPTH must be a power of two, at least 2.
module shared_memory_rd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DW-1:0]               wdata,
  output logic [DW-1:0]               rdata,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(push && full));
  assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/shared_memory_block_master.sv
// Avalon-MM master moving word blocks between the sink/source streams and the
// 1024x32 shared memory (latency-1 slave, no waitrequest).
module shared_memory_block_master
  import shared_memory_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  shared_memory_block_master_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic          inflight_q, inflight_d;

  logic          wr_beat;
  logic          rd_issue;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [DW-1:0] fifo_rdata;

  // Words already buffered plus the one returning this cycle must leave room for another read.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign wr_beat     = (state_q == WRITE) && bus.snk_valid;
  assign rd_issue    = (state_q == READ) && (remaining_q != '0) && !fifo_full
                       && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign fifo_pop    = !fifo_empty && bus.src_ready;

  assign bus.cmd_ready      = (state_q == IDLE);
  assign bus.done           = (state_q == FINISH);
  assign bus.snk_ready      = (state_q == WRITE);
  assign bus.src_valid      = !fifo_empty;
  assign bus.src_data       = fifo_rdata;
  assign bus.avm_chipselect = wr_beat || rd_issue;
  assign bus.avm_write      = wr_beat;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = bus.snk_data;
  assign bus.avm_byteenable = BE_ALL;
  assign bus.avm_clken      = 1'b1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    inflight_d  = rd_issue;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            state_d = FINISH;
          end else begin
            case (bus.cmd_write)
              CMD_WRITE: state_d = WRITE;
              CMD_READ:  state_d = READ;
              default:   state_d = IDLE;
            endcase
          end
        end
      end
      WRITE: begin
        if (wr_beat) begin
          addr_d      = addr_q + AW'(1);
          remaining_d = remaining_q - (AW+1)'(1);
          if (remaining_q == (AW+1)'(1)) begin
            state_d = FINISH;
          end
        end
      end
      READ: begin
        if (rd_issue) begin
          addr_d      = addr_q + AW'(1);
          remaining_d = remaining_q - (AW+1)'(1);
          if (remaining_q == (AW+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
    end
  end

  // Read data is valid the cycle after issue, so the in-flight flag doubles as the push strobe.
  shared_memory_rd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DW         (DW)
  ) u_rd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight_q),
    .pop     (fifo_pop),
    .wdata   (bus.avm_readdata),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: doc/shared_memory_block_master.md
Name: shared_memory_block_master

Overview:
- Avalon-MM master that moves word blocks between a streaming interface and the single-port 1024x32 shared on-chip memory.
- The shared memory is the slave: read latency 1, no waitrequest.
- Write command: words accepted on the sink stream are written to consecutive memory addresses.
- Read command: consecutive words are read from memory and presented on the source stream, with backpressure.
- Sits between the Car2x packet datapath and the Nios shared-memory slave port.

Parameters:
- AW, 10, memory word-address width (1024 words).
- DW, 32, data width; byteenable width is DW/8.
- FIFO_DEPTH, 4, read-return buffer depth in words; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = stream->memory, 0 = memory->stream.
- cmd_addr  in  AW  start word address.
- cmd_len  in  AW+1  word count, 0..1024.
- done  out  1  one-cycle pulse when a command completes.
- snk_data  in  DW  write-stream data.
- snk_valid  in  1  write-stream valid.
- snk_ready  out  1  write-stream ready.
- src_data  out  DW  read-stream data.
- src_valid  out  1  read-stream valid.
- src_ready  in  1  read-stream ready.
- avm_address  out  AW  memory word address.
- avm_chipselect  out  1  memory select.
- avm_write  out  1  write strobe.
- avm_byteenable  out  DW/8  constant all-ones.
- avm_writedata  out  DW  write data.
- avm_clken  out  1  constant 1.
- avm_readdata  in  DW  read data, valid 1 cycle after the read issue.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE; FIFO emptied; in-flight flag, counters and address register cleared.
  - Outputs: cmd_ready=1 (IDLE), done=0, snk_ready=0, src_valid=0, avm_chipselect=0, avm_write=0, avm_address=0.
  - Reset mid-command abandons the command; no done pulse; memory contents already written are kept.
- States: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE:
  - cmd_valid&cmd_ready latches addr and remaining=cmd_len.
  - len==0 -> FINISH. Otherwise -> WRITE if cmd_write=1, else READ.
- WRITE:
  - snk_ready=1.
  - A beat transfers when snk_valid=1; that same cycle: avm_chipselect=1, avm_write=1, avm_writedata=snk_data, avm_address=addr (combinational from the registered addr).
  - On each beat: addr<=addr+1 (mod 2^AW, 1023 wraps to 0), remaining-=1.
  - Last beat -> FINISH.
  - snk_valid low stalls the command with no timeout.
- READ:
  - Issue condition: remaining!=0 and (fifo_count + inflight) < FIFO_DEPTH.
  - Issue cycle: avm_chipselect=1, avm_write=0, avm_address=addr; set inflight; addr++, remaining--.
  - The cycle after an issue, avm_readdata is pushed into the FIFO.
  - Reads may issue back-to-back, one per cycle.
  - After the last issue -> DRAIN.
- DRAIN:
  - No memory access.
  - Wait until inflight=0 and the FIFO is empty -> FINISH.
- FINISH: done=1 for exactly one cycle -> IDLE.
- Source stream:
  - src_valid = FIFO not empty; src_data = FIFO head; pop on src_valid&src_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - The credit check guarantees the FIFO never overflows. A push while full is an assertion failure.
  - src_data/src_valid are held stable while src_ready=0.
- Length 1024 covers all of memory; the start address may be nonzero, in which case the address wraps.
- snk_ready=0 in every state except WRITE. Sink beats outside WRITE are ignored and not consumed.

Decomposition:
- Package shared_memory_pkg:
  - AW, DW and the constant byteenable value.
  - State enum {IDLE, WRITE, READ, DRAIN, FINISH}.
  - Command-direction constants.
- One sub-module: shared_memory_rd_fifo.
  - Synchronous FIFO, parameter FIFO_DEPTH.
  - Ports: push, pop, data in/out, count, empty, full.
  - Same clk/reset_n.

Test Plan:
- Write, no stalls: cmd addr=0x010, len=4, write=1; snk beats 0xA0..0xA3 -> avm writes at 0x010..0x013 on consecutive cycles; done pulses 1 cycle after the last beat.
- Read, no stalls: after the write above, cmd addr=0x010, len=4, write=0, src_ready=1 -> src emits 0xA0..0xA3 in order, first beat 2 cycles after the command accept; done after the last pop.
- Read backpressure: len=8, src_ready=0 for 20 cycles -> exactly 4 read issues, then chipselect stays 0; on release, remaining 4 issue; all 8 words delivered in order, none lost or duplicated.
- Wrap-around: write cmd addr=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; read-back matches.
- Zero length: cmd len=0 (either direction) -> no chipselect ever; done one cycle after accept; cmd_ready returns.
- Mid-operation reset: reset_n low for 1 cycle during a read of len=8 after 3 pops -> src_valid=0, cmd_ready=1 next cycle, no done; a new command then runs correctly.
